pls_cnt_mod: RTL and testbench
==============================

Name: pls_cnt_mod

Overview:
- Parametrised modulo-N pulse counter for the watch datapath. Generalises the fixed decade counter.
- Adds the following:
  - selectable modulus and count edge;
  - up/down counting with borrow;
  - synchronous preset (time-set);
  - count enable;
  - a one-clock wrap pulse for cascading seconds → minutes → hours stages.
- Sits between the button/tick conditioning logic and the BCD display path.

Parameters:
- MOD, 10: counter modulus. qout ranges 0..MOD-1. MOD ≥ 2.
- W, 6: qout/ld_val width. Must satisfy 2^W ≥ MOD; elaboration fails otherwise.
- EDGE_FALL, 1: 1 counts on plsi falling edge; 0 counts on plsi rising edge.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- clr, input, 1: clear request, asynchronous source. Rising edge acts.
- plsi, input, 1: count pulse, asynchronous source. The edge selected by EDGE_FALL acts.
- en, input, 1: synchronous count enable.
- dn, input, 1: synchronous direction. 0 = up, 1 = down.
- ld, input, 1: synchronous load strobe, level-sampled each clk.
- ld_val, input, W: preset value.
- qout, output, W: current count (registered).
- plso, output, 1: wrap/borrow pulse (registered), high for exactly one clk.
- tc, output, 1: terminal count. Up: qout == MOD-1. Down: qout == 0. Decoded from registers.

Behaviour:
- Reset (rst = 0, async): qout = 0, plso = 0, all synchroniser/history flops = 0. tc follows its decode, so tc = 1 if dn = 1.
- clr and plsi each pass through a 2-flop synchroniser plus one history flop. An edge is detected between sync stage 2 and history.
- Latency: the counted action updates qout on the 2nd rising clk after the clk that first samples the new input level. plso rises on that same clk.
- ld, en and dn are synchronous and not synchronised. They act on the clk where sampled.
- Priority per clk, highest first:
  1. clr edge: qout ← 0, plso ← 0. Any pulse edge detected in the same clk is discarded. History flops are forced equal to sync stage 2, so no spurious edge follows.
  2. ld = 1: qout ← ld_val, or MOD-1 if ld_val ≥ MOD (clamp). plso ← 0. A coincident pulse edge is discarded.
  3. Pulse edge with en = 1:
     - up: qout == MOD-1 → qout ← 0, plso ← 1. Otherwise qout + 1, plso ← 0.
     - down: qout == 0 → qout ← MOD-1, plso ← 1. Otherwise qout - 1, plso ← 0.
  4. Otherwise: qout holds, plso ← 0.
- Pulse edges with en = 0 are dropped, not queued.
- A dn change takes effect on the next counted edge.
- If qout is ever ≥ MOD (not reachable by design), the next up edge wraps to 0 with plso = 1.
- Held ld: qout is reloaded every clk while ld = 1.
- Cascading: plso of stage k drives plsi of stage k+1. With EDGE_FALL = 1, the next stage counts on plso's falling edge, one clk after the wrap.

Decomposition:
- Shared package watch_cnt_pkg:
  - constants MOD_DEC = 10, MOD_SEC = 60, MOD_MIN = 60, MOD_HR = 24, MOD_HR12 = 12;
  - matching widths W_DEC = 4, W_SEC = 6, W_HR = 5.
- Sub-module pls_edge_sync:
  - function: 2-flop synchroniser + history flop + edge output;
  - parameter: EDGE_FALL;
  - input: flush (forces history = sync stage 2);
  - instantiated twice: clr with rising edge, plsi with EDGE_FALL.

Test Plan:
1. MOD = 10, up, en = 1: 12 falling plsi pulses from reset. qout runs 1..9, 0, 1, 2. plso is high for one clk at the 9→0 wrap only. Each update lands 2 clks after the first sampling clk.
2. MOD = 60, dn = 1, from qout = 0: one pulse gives qout = 59 with plso = 1. A second pulse gives 58 with plso = 0. tc = 1 only while qout = 0.
3. MOD = 24: ld = 1, ld_val = 30 gives qout = 23 (clamp). ld_val = 7 gives qout = 7. A pulse edge coinciding with the ld clk is discarded, and qout stays 7.
4. qout = 5: clr rise and plsi falling edge synchronised into the same clk. Result: qout = 0, plso = 0, and no count on the following clks.
5. en = 0 during 3 pulses: qout unchanged. en = 1 and one pulse: qout + 1 only. rst asserted mid-pulse: qout = 0 and plso = 0 immediately, without waiting for clk.
6. Cascade MOD_SEC → MOD_MIN, both EDGE_FALL = 1: 60 pulses into seconds give seconds = 0, minutes = 1, and exactly one plso pulse from the seconds stage.

Source files
------------

// File: rtl/watch_cnt_pkg.sv
// Shared constants and types for the watch counter chain (seconds, minutes, hours).
// Moduli and widths are kept together so cascaded stages stay consistent.
package watch_cnt_pkg;

  localparam int MOD_DEC  = 10;
  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HR   = 24;
  localparam int MOD_HR12 = 12;

  localparam int W_DEC = 4;
  localparam int W_SEC = 6;
  localparam int W_HR  = 5;

  // Action chosen for the counter register on a given clk, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_UP,
    ACT_DOWN
  } cnt_act_e;

endpackage

// File: rtl/pls_edge_sync.sv
// Two-flop synchroniser plus history flop for an asynchronous pulse source.
// Produces a one-clk edge strobe; flush realigns history with sync stage 2.
module pls_edge_sync #(
  parameter bit EDGE_FALL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic flush,
  output logic edge_det
);

  logic s1;
  logic s2;
  logic hist;

  // On flush, history takes the value stage 2 is about to hold, so an edge
  // still travelling through the synchroniser is swallowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= flush ? s1 : s2;
    end
  end

  generate
    if (EDGE_FALL) begin : g_fall
      assign edge_det = hist & ~s2;
    end else begin : g_rise
      assign edge_det = s2 & ~hist;
    end
  endgenerate

endmodule

// File: rtl/pls_cnt_mod.sv
// Modulo-MOD up/down pulse counter with clear, preset, enable and a one-clk
// wrap/borrow pulse intended to drive the pulse input of the next stage.
module pls_cnt_mod
  import watch_cnt_pkg::*;
#(
  parameter int MOD       = 10,
  parameter int W         = 6,
  parameter bit EDGE_FALL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         plsi,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] qout,
  output logic         plso,
  output logic         tc
);

  generate
    if (MOD < 2 || (64'd1 << W) < 64'(MOD)) begin : g_param_check
      $error("pls_cnt_mod: need MOD >= 2 and 2**W >= MOD");
    end
  endgenerate

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic         clr_edge;
  logic         pls_edge;
  cnt_act_e     act;
  logic [W-1:0] q_next;
  logic         plso_next;

  pls_edge_sync #(.EDGE_FALL(1'b0)) u_clr_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (clr),
    .flush    (1'b0),
    .edge_det (clr_edge)
  );

  pls_edge_sync #(.EDGE_FALL(EDGE_FALL)) u_pls_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (plsi),
    .flush    (clr_edge),
    .edge_det (pls_edge)
  );

  always_comb begin
    act = ACT_HOLD;
    if (clr_edge) begin
      act = ACT_CLR;
    end else if (ld) begin
      act = ACT_LOAD;
    end else if (pls_edge && en) begin
      act = dn ? ACT_DOWN : ACT_UP;
    end
  end

  // Up-wrap tests >= TOP so an out-of-range value recovers on the next edge.
  always_comb begin
    q_next    = qout;
    plso_next = 1'b0;
    case (act)
      ACT_CLR:  q_next = '0;
      ACT_LOAD: q_next = (ld_val > TOP) ? TOP : ld_val;
      ACT_UP: begin
        if (qout >= TOP) begin
          q_next    = '0;
          plso_next = 1'b1;
        end else begin
          q_next = qout + 1'b1;
        end
      end
      ACT_DOWN: begin
        if (qout == '0) begin
          q_next    = TOP;
          plso_next = 1'b1;
        end else begin
          q_next = qout - 1'b1;
        end
      end
      default: q_next = qout;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qout <= '0;
      plso <= 1'b0;
    end else begin
      qout <= q_next;
      plso <= plso_next;
    end
  end

  assign tc = dn ? (qout == '0) : (qout == TOP);

endmodule

// File: tb/tb_pls_cnt_mod.sv
// Directed bench for pls_cnt_mod: decade, seconds, hours and a cascaded
// seconds->minutes pair, with a per-clk vector table for load/clear cases.
module tb_pls_cnt_mod;
  import watch_cnt_pkg::*;

  logic clk;
  logic rst;

  logic             dec_clr, dec_plsi, dec_en, dec_dn, dec_ld;
  logic [W_DEC-1:0] dec_ld_val, dec_q;
  logic             dec_plso, dec_tc;

  logic             sec_clr, sec_plsi, sec_en, sec_dn, sec_ld;
  logic [W_SEC-1:0] sec_ld_val, sec_q;
  logic             sec_plso, sec_tc;

  logic             hr_clr, hr_plsi, hr_en, hr_dn, hr_ld;
  logic [W_HR-1:0]  hr_ld_val, hr_q;
  logic             hr_plso, hr_tc;

  logic             cs_clr, cs_plsi, cs_en, cs_dn, cs_ld;
  logic [W_SEC-1:0] cs_ld_val, cs_q;
  logic             cs_plso, cs_tc;

  logic             cm_clr, cm_en, cm_dn, cm_ld;
  logic [W_SEC-1:0] cm_ld_val, cm_q;
  logic             cm_plso, cm_tc;

  int n_chk;
  int n_fail;
  int n_cas;
  int exp_dec [12];
  logic [W_DEC-1:0] prev_dec;

  typedef struct {
    logic            clr;
    logic            plsi;
    logic            dn;
    logic            ld;
    logic [W_HR-1:0] ld_val;
    logic [W_HR-1:0] q;
    logic            plso;
    logic            tc;
  } vec_t;

  localparam int N_VEC = 28;
  vec_t vec [N_VEC];

  pls_cnt_mod #(.MOD(MOD_DEC), .W(W_DEC), .EDGE_FALL(1'b1)) u_dec (
    .clk(clk), .rst(rst), .clr(dec_clr), .plsi(dec_plsi), .en(dec_en), .dn(dec_dn),
    .ld(dec_ld), .ld_val(dec_ld_val), .qout(dec_q), .plso(dec_plso), .tc(dec_tc)
  );

  pls_cnt_mod #(.MOD(MOD_SEC), .W(W_SEC), .EDGE_FALL(1'b1)) u_sec (
    .clk(clk), .rst(rst), .clr(sec_clr), .plsi(sec_plsi), .en(sec_en), .dn(sec_dn),
    .ld(sec_ld), .ld_val(sec_ld_val), .qout(sec_q), .plso(sec_plso), .tc(sec_tc)
  );

  pls_cnt_mod #(.MOD(MOD_HR), .W(W_HR), .EDGE_FALL(1'b1)) u_hr (
    .clk(clk), .rst(rst), .clr(hr_clr), .plsi(hr_plsi), .en(hr_en), .dn(hr_dn),
    .ld(hr_ld), .ld_val(hr_ld_val), .qout(hr_q), .plso(hr_plso), .tc(hr_tc)
  );

  pls_cnt_mod #(.MOD(MOD_SEC), .W(W_SEC), .EDGE_FALL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .clr(cs_clr), .plsi(cs_plsi), .en(cs_en), .dn(cs_dn),
    .ld(cs_ld), .ld_val(cs_ld_val), .qout(cs_q), .plso(cs_plso), .tc(cs_tc)
  );

  pls_cnt_mod #(.MOD(MOD_MIN), .W(W_SEC), .EDGE_FALL(1'b1)) u_cm (
    .clk(clk), .rst(rst), .clr(cm_clr), .plsi(cs_plso), .en(cm_en), .dn(cm_dn),
    .ld(cm_ld), .ld_val(cm_ld_val), .qout(cm_q), .plso(cm_plso), .tc(cm_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic clr, input logic plsi, input logic dn, input logic ld,
                              input int ld_val, input int q, input logic plso, input logic tc);
    vec_t v;
    v.clr    = clr;
    v.plsi   = plsi;
    v.dn     = dn;
    v.ld     = ld;
    v.ld_val = W_HR'(ld_val);
    v.q      = W_HR'(q);
    v.plso   = plso;
    v.tc     = tc;
    return v;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_cas  = 0;
    exp_dec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // Per-clk vectors for the MOD=24 stage: {clr, plsi, dn, ld, ld_val, q, plso, tc}.
    // A plsi fall driven at step i is counted in the qout visible at step i+2.
    vec[0]  = mk(0, 1, 0, 1, 30, 23, 0, 1);
    vec[1]  = mk(0, 1, 0, 1,  7,  7, 0, 0);
    vec[2]  = mk(0, 1, 0, 0,  0,  7, 0, 0);
    vec[3]  = mk(0, 0, 0, 0,  0,  7, 0, 0);
    vec[4]  = mk(0, 0, 0, 0,  0,  7, 0, 0);
    vec[5]  = mk(0, 0, 0, 1,  7,  7, 0, 0);
    vec[6]  = mk(0, 1, 0, 0,  0,  7, 0, 0);
    vec[7]  = mk(0, 1, 0, 0,  0,  7, 0, 0);
    vec[8]  = mk(0, 1, 0, 0,  0,  7, 0, 0);
    vec[9]  = mk(0, 0, 0, 0,  0,  7, 0, 0);
    vec[10] = mk(0, 0, 0, 0,  0,  7, 0, 0);
    vec[11] = mk(0, 0, 0, 0,  0,  8, 0, 0);
    vec[12] = mk(0, 1, 0, 0,  0,  8, 0, 0);
    vec[13] = mk(0, 1, 0, 0,  0,  8, 0, 0);
    vec[14] = mk(0, 1, 0, 1,  5,  5, 0, 0);
    vec[15] = mk(0, 1, 0, 0,  0,  5, 0, 0);
    vec[16] = mk(1, 0, 0, 0,  0,  5, 0, 0);
    vec[17] = mk(1, 0, 0, 0,  0,  5, 0, 0);
    vec[18] = mk(1, 0, 0, 0,  0,  0, 0, 0);
    vec[19] = mk(0, 0, 0, 0,  0,  0, 0, 0);
    vec[20] = mk(0, 0, 0, 0,  0,  0, 0, 0);
    vec[21] = mk(0, 1, 0, 0,  0,  0, 0, 0);
    vec[22] = mk(0, 1, 0, 0,  0,  0, 0, 0);
    vec[23] = mk(0, 0, 1, 0,  0,  0, 0, 1);
    vec[24] = mk(0, 0, 1, 0,  0,  0, 0, 1);
    vec[25] = mk(0, 0, 1, 0,  0, 23, 1, 0);
    vec[26] = mk(0, 1, 1, 0,  0, 23, 0, 0);
    vec[27] = mk(0, 1, 0, 0,  0, 23, 0, 1);

    rst = 1'b0;
    dec_clr = 0; dec_plsi = 1; dec_en = 1; dec_dn = 0; dec_ld = 0; dec_ld_val = '0;
    sec_clr = 0; sec_plsi = 1; sec_en = 1; sec_dn = 1; sec_ld = 0; sec_ld_val = '0;
    hr_clr  = 0; hr_plsi  = 1; hr_en  = 1; hr_dn  = 0; hr_ld  = 0; hr_ld_val  = '0;
    cs_clr  = 0; cs_plsi  = 1; cs_en  = 1; cs_dn  = 0; cs_ld  = 0; cs_ld_val  = '0;
    cm_clr  = 0;               cm_en  = 1; cm_dn  = 0; cm_ld  = 0; cm_ld_val  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_dec_q", dec_q, 0);
    chk("rst_dec_plso", dec_plso, 0);
    chk("rst_dec_tc", dec_tc, 0);
    chk("rst_sec_tc_dn", sec_tc, 1);
    chk("rst_hr_q", hr_q, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Test 1: decade up-count with latency and wrap pulse
    prev_dec = '0;
    for (int i = 0; i < 12; i++) begin
      dec_plsi = 1'b0;
      tick();
      tick();
      chk($sformatf("t1_hold[%0d]", i), dec_q, prev_dec);
      tick();
      chk($sformatf("t1_q[%0d]", i), dec_q, exp_dec[i]);
      chk($sformatf("t1_plso[%0d]", i), dec_plso, (i == 9) ? 1 : 0);
      chk($sformatf("t1_tc[%0d]", i), dec_tc, (exp_dec[i] == 9) ? 1 : 0);
      dec_plsi = 1'b1;
      tick();
      chk($sformatf("t1_plso_off[%0d]", i), dec_plso, 0);
      tick();
      prev_dec = W_DEC'(exp_dec[i]);
    end

    // Test 2: MOD 60 down-count borrow
    chk("t2_tc_at0", sec_tc, 1);
    sec_plsi = 1'b0;
    repeat (3) tick();
    chk("t2_q59", sec_q, 59);
    chk("t2_plso_borrow", sec_plso, 1);
    chk("t2_tc59", sec_tc, 0);
    sec_plsi = 1'b1;
    tick();
    chk("t2_plso_off", sec_plso, 0);
    tick();
    sec_plsi = 1'b0;
    repeat (3) tick();
    chk("t2_q58", sec_q, 58);
    chk("t2_plso58", sec_plso, 0);
    chk("t2_tc58", sec_tc, 0);
    sec_plsi = 1'b1;
    repeat (2) tick();

    // Tests 3/4: load clamp, load vs pulse, clear vs pulse, down wrap (table)
    for (int i = 0; i < N_VEC; i++) begin
      hr_clr    = vec[i].clr;
      hr_plsi   = vec[i].plsi;
      hr_dn     = vec[i].dn;
      hr_ld     = vec[i].ld;
      hr_ld_val = vec[i].ld_val;
      tick();
      chk($sformatf("tbl_q[%0d]", i), hr_q, vec[i].q);
      chk($sformatf("tbl_plso[%0d]", i), hr_plso, vec[i].plso);
      chk($sformatf("tbl_tc[%0d]", i), hr_tc, vec[i].tc);
    end
    hr_ld = 1'b0;
    hr_dn = 1'b0;

    // Test 5: enable gating, then asynchronous reset mid-pulse
    dec_en = 1'b0;
    repeat (3) begin
      dec_plsi = 1'b0;
      repeat (3) tick();
      dec_plsi = 1'b1;
      repeat (2) tick();
    end
    chk("t5_en0_hold", dec_q, 2);
    dec_en = 1'b1;
    dec_plsi = 1'b0;
    repeat (3) tick();
    chk("t5_en1_inc", dec_q, 3);
    dec_plsi = 1'b1;
    repeat (2) tick();
    chk("t5_en1_once", dec_q, 3);
    dec_plsi = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    chk("t5_async_q", dec_q, 0);
    chk("t5_async_plso", dec_plso, 0);
    chk("t5_async_hr_q", hr_q, 0);
    dec_plsi = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t5_post_rst_q", dec_q, 0);

    // Test 6: seconds -> minutes cascade
    for (int i = 0; i < 60; i++) begin
      cs_plsi = 1'b0;
      repeat (2) begin
        tick();
        if (cs_plso) n_cas++;
      end
      cs_plsi = 1'b1;
      repeat (2) begin
        tick();
        if (cs_plso) n_cas++;
      end
      if (i == 29) begin
        chk("t6_sec_mid", cs_q, 30);
        chk("t6_min_mid", cm_q, 0);
      end
    end
    repeat (6) begin
      tick();
      if (cs_plso) n_cas++;
    end
    chk("t6_sec_wrap", cs_q, 0);
    chk("t6_min_inc", cm_q, 1);
    chk("t6_plso_count", n_cas, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
